bram_sd_sync: RTL and testbench

Slot-based backup-RAM persistence controller: moves the console's battery-backed RAM between the on-chip dual-port backup RAM and the mounted SD save image, one 512-byte sector at a time, through the hps_io sector interface in WIDE (16-bit) mode. It generalises the fixed 4-slot/16-sector load/save sequencer of the TGFX16 core to parametrised slot and sector counts. It adds dirty tracking with delayed auto-save, an SD acknowledge timeout with error reporting, and header-word formatting. It sits in the emu top level between hps_io and port B of the backup RAM.

---
 rtl/bram_sd_sync.sv | 220 ++++++++++++++++++++++
 tb/tb_bram_sd_sync.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sd_sync.sv
// Backup-RAM persistence controller: moves save slots between the on-chip backup RAM
// (port B) and the SD save image sector by sector, with auto-save, ack timeout and formatting.
module bram_sd_sync #(
    parameter int           SLOTS       = 4,
    parameter int           SECTORS     = 16,
    parameter int           HDR_WORDS   = 4,
    parameter logic [127:0] HDR         = {16'h5548, 16'h4D42, 16'h8800, 16'h8010, 64'h0},
    parameter int           AS_DELAY    = 21_000_000,
    parameter int           ACK_TIMEOUT = 2_000_000,
    localparam int          SW          = (SECTORS > 1) ? $clog2(SECTORS) : 1,
    localparam int          SLW         = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic           ena,
    input  logic [SLW-1:0] slot,
    input  logic           load_req,
    input  logic           save_req,
    input  logic           format_req,
    input  logic           autosave_en,
    input  logic           bram_dirty,
    output logic [31:0]    sd_lba,
    output logic           sd_rd,
    output logic           sd_wr,
    input  logic           sd_ack,
    input  logic [7:0]     sd_buff_addr,
    input  logic [15:0]    sd_buff_dout,
    input  logic           sd_buff_wr,
    output logic [SW+7:0]  ram_addr,
    output logic [15:0]    ram_din,
    output logic           ram_we,
    output logic           loading,
    output logic           busy,
    output logic           dirty,
    output logic           err,
    output logic           done
);

    localparam int ASW = $clog2(AS_DELAY + 1);
    localparam int TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER, FMT} state_t;

    state_t         state, state_n;
    logic [SW-1:0]  sector, sector_n;
    logic [SLW-1:0] slot_q, slot_n;
    logic           op_rd, op_rd_n;
    logic [TW-1:0]  tcnt, tcnt_n;
    logic [2:0]     fmt_i, fmt_n;
    logic [ASW-1:0] as_cnt;
    logic           rd_n, wr_n, loading_n, err_n, done_n, dirty_n;
    logic           dirty_set, dirty_clr, start_ld, start_sv;
    logic           ld_p0, ld_p1, sv_p0, sv_p1, fm_p0, fm_p1, wr_p0;
    logic           ld_rise, sv_rise, fm_rise, as_go;

    function automatic logic [SLW-1:0] clamp_slot(input logic [SLW-1:0] s);
        if (32'(s) >= SLOTS) return SLW'(SLOTS - 1);
        return s;
    endfunction

    function automatic logic [15:0] hdr_word(input logic [2:0] i);
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < 8; k++)
            if (i == 3'(k)) w = HDR[127-16*k -: 16];
        return w;
    endfunction

    // Request inputs are registered twice so edges are detected one cycle after sampling
    assign ld_rise = ld_p0 & ~ld_p1;
    assign sv_rise = sv_p0 & ~sv_p1;
    assign fm_rise = fm_p0 & ~fm_p1;
    assign as_go   = autosave_en & dirty & (as_cnt == ASW'(AS_DELAY));
    assign sd_lba  = 32'(slot_q) * 32'(SECTORS) + 32'(sector);
    assign busy    = (state != IDLE);

    always_comb begin
        state_n   = state;
        sector_n  = sector;
        slot_n    = slot_q;
        op_rd_n   = op_rd;
        tcnt_n    = tcnt;
        fmt_n     = fmt_i;
        rd_n      = sd_rd;
        wr_n      = sd_wr;
        loading_n = loading;
        err_n     = err;
        done_n    = 1'b0;
        dirty_set = 1'b0;
        dirty_clr = 1'b0;
        start_ld  = 1'b0;
        start_sv  = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (ena) begin
                    if (ld_rise)      start_ld = 1'b1;
                    else if (sv_rise) start_sv = 1'b1;
                    else if (fm_rise) begin
                        fmt_n   = '0;
                        state_n = FMT;
                    end
                    else if (as_go)   start_sv = 1'b1;
                end
                if (start_ld || start_sv) begin
                    slot_n    = clamp_slot(slot);
                    sector_n  = '0;
                    op_rd_n   = start_ld;
                    rd_n      = start_ld;
                    wr_n      = start_sv;
                    loading_n = start_ld;
                    err_n     = 1'b0;
                    tcnt_n    = '0;
                    dirty_clr = start_sv;
                    state_n   = REQ;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = XFER;
                end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
                    rd_n      = 1'b0;
                    wr_n      = 1'b0;
                    loading_n = 1'b0;
                    err_n     = 1'b1;
                    state_n   = IDLE;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            XFER: begin
                ram_addr = {sector, sd_buff_addr};
                ram_din  = sd_buff_dout;
                ram_we   = sd_buff_wr & sd_ack & op_rd;
                // XFER is only entered with sd_ack high, so a low ack here is the falling edge
                if (!sd_ack) begin
                    if (sector == SW'(SECTORS - 1)) begin
                        done_n    = 1'b1;
                        loading_n = 1'b0;
                        dirty_clr = op_rd;
                        state_n   = IDLE;
                    end else begin
                        sector_n = sector + SW'(1);
                        tcnt_n   = '0;
                        rd_n     = op_rd;
                        wr_n     = ~op_rd;
                        state_n  = REQ;
                    end
                end
            end
            FMT: begin
                ram_addr = (SW+8)'(fmt_i);
                ram_din  = hdr_word(fmt_i);
                ram_we   = 1'b1;
                if (fmt_i == 3'(HDR_WORDS - 1)) begin
                    done_n    = 1'b1;
                    dirty_set = 1'b1;
                    state_n   = IDLE;
                end else begin
                    fmt_n = fmt_i + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        dirty_n = (wr_p0 | dirty_set) ? 1'b1 : (dirty_clr ? 1'b0 : dirty);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            sector  <= '0;
            slot_q  <= '0;
            op_rd   <= 1'b0;
            tcnt    <= '0;
            fmt_i   <= '0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            loading <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
            dirty   <= 1'b0;
            as_cnt  <= '0;
            ld_p0   <= 1'b0;
            ld_p1   <= 1'b0;
            sv_p0   <= 1'b0;
            sv_p1   <= 1'b0;
            fm_p0   <= 1'b0;
            fm_p1   <= 1'b0;
            wr_p0   <= 1'b0;
        end else begin
            state   <= state_n;
            sector  <= sector_n;
            slot_q  <= slot_n;
            op_rd   <= op_rd_n;
            tcnt    <= tcnt_n;
            fmt_i   <= fmt_n;
            sd_rd   <= rd_n;
            sd_wr   <= wr_n;
            loading <= loading_n;
            err     <= err_n;
            done    <= done_n;
            dirty   <= dirty_n;
            ld_p0   <= load_req;
            ld_p1   <= ld_p0;
            sv_p0   <= save_req;
            sv_p1   <= sv_p0;
            fm_p0   <= format_req;
            fm_p1   <= fm_p0;
            wr_p0   <= bram_dirty;
            // Idle counter restarts on every core write and parks at AS_DELAY
            if (wr_p0)                            as_cnt <= '0;
            else if (as_cnt != ASW'(AS_DELAY))    as_cnt <= as_cnt + ASW'(1);
        end
    end

endmodule

// File: tb/tb_bram_sd_sync.sv
// Scoreboard bench for bram_sd_sync: emulates the hps_io sector host and checks
// load, save, format, timeout, auto-save and reset-abort behaviour.
module tb_bram_sd_sync;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0, ena = 1'b0;
    logic [1:0]  slot = '0;
    logic        load_req = 1'b0, save_req = 1'b0, format_req = 1'b0;
    logic        autosave_en = 1'b0, bram_dirty = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [7:0]  sd_buff_addr = '0;
    logic [15:0] sd_buff_dout = '0;
    logic        sd_buff_wr = 1'b0;
    logic [11:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_we, loading, busy, dirty, err, done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_lba[$];
    logic [27:0] exp_fmt[$];

    bram_sd_sync #(.SLOTS(4), .SECTORS(16), .HDR_WORDS(4), .AS_DELAY(100), .ACK_TIMEOUT(64)) dut (
        .clk_sys(clk_sys), .reset(reset), .ena(ena), .slot(slot),
        .load_req(load_req), .save_req(save_req), .format_req(format_req),
        .autosave_en(autosave_en), .bram_dirty(bram_dirty),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .loading(loading), .busy(busy), .dirty(dirty), .err(err), .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Host side of one sector: wait for the request, ack after 5 cycles, stream 16 words.
    // Returns the observed LBA and a count of protocol anomalies for the caller to judge.
    task automatic sd_host(input bit is_rd, input bit exp_load, output logic [31:0] lba,
                           output bit tmo, output int we_cnt, output int bad);
        int n;
        logic [15:0] d;
        tmo = 1'b0; we_cnt = 0; bad = 0; lba = '0; n = 0;
        while (!(is_rd ? sd_rd : sd_wr) && n < 50) begin
            if (ram_we || done) bad++;
            tick();
            n++;
        end
        if (n >= 50) begin
            tmo = 1'b1;
            return;
        end
        lba = sd_lba;
        repeat (4) begin
            if (ram_we || done || sd_lba !== lba || loading !== exp_load) bad++;
            tick();
        end
        sd_ack = 1'b1;
        tick();
        if (sd_rd || sd_wr) bad++;
        for (int w = 0; w < 16; w++) begin
            d = lba[15:0] * 16'd31 + 16'(w);
            sd_buff_addr = 8'(w);
            sd_buff_dout = d;
            sd_buff_wr = 1'b1;
            #1;
            if (ram_we) we_cnt++;
            if (ram_we !== is_rd || sd_lba !== lba || loading !== exp_load || done) bad++;
            if (is_rd && (ram_addr !== {lba[3:0], 8'(w)} || ram_din !== d)) bad++;
            tick();
        end
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({sd_lba, sd_rd, sd_wr, ram_we, ram_addr, ram_din} !== '0)
            $display("FAIL reset_sd_ram: got lba=%0h rd=%0b wr=%0b we=%0b addr=%0h din=%0h, want all 0",
                     sd_lba, sd_rd, sd_wr, ram_we, ram_addr, ram_din);
        n_cmp++;
        if ({loading, busy, dirty, err, done} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_status: got %b, want 00000", {loading, busy, dirty, err, done});
        end
        if ({sd_lba, sd_rd, sd_wr, ram_we, ram_addr, ram_din} !== '0) n_bad++;
        reset = 1'b0;
        ena = 1'b1;
        tick();
    endtask

    task automatic test_load();
        logic [31:0] l, e;
        bit t;
        int wc, b, we_sum, bad_sum, ld_low;
        slot = 2'd2;
        for (int i = 0; i < 16; i++) exp_lba.push_back(32 + i);
        load_req = 1'b1;
        tick();
        n_cmp++;
        if (sd_rd !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL load_early: got rd=%0b busy=%0b, want 0 0", sd_rd, busy);
        end
        tick();
        n_cmp++;
        if ({sd_rd, sd_wr, loading, busy} !== 4'b1011) begin
            n_bad++;
            $display("FAIL load_start: got rd/wr/loading/busy=%b, want 1011", {sd_rd, sd_wr, loading, busy});
        end
        load_req = 1'b0;
        we_sum = 0; bad_sum = 0; ld_low = 0;
        for (int i = 0; i < 16; i++) begin
            sd_host(1'b1, 1'b1, l, t, wc, b);
            e = exp_lba.pop_front();
            n_cmp++;
            if (t || l !== e) begin
                n_bad++;
                $display("FAIL load_lba: got %0d (timeout=%0b), want %0d", l, t, e);
            end
            we_sum += wc;
            bad_sum += b;
        end
        n_cmp++;
        if (we_sum != 256 || bad_sum != 0) begin
            n_bad++;
            $display("FAIL load_xfer: got we=%0d anomalies=%0d, want 256 0", we_sum, bad_sum);
        end
        n_cmp++;
        if ({done, loading, busy, dirty} !== 4'b1000) begin
            n_bad++;
            $display("FAIL load_done: got done/loading/busy/dirty=%b, want 1000", {done, loading, busy, dirty});
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL load_done_pulse: got done=%0b, want 0", done);
        end
    endtask

    task automatic test_format();
        logic [15:0] hw[4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};
        logic [27:0] e;
        int we_n, done_n, last_we, done_c, bad;
        for (int i = 0; i < 4; i++) exp_fmt.push_back({12'(i), hw[i]});
        format_req = 1'b1;
        tick();
        tick();
        format_req = 1'b0;
        we_n = 0; done_n = 0; last_we = -1; done_c = -1; bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (ram_we) begin
                we_n++;
                last_we = c;
                if (exp_fmt.size() == 0) bad++;
                else begin
                    e = exp_fmt.pop_front();
                    if ({ram_addr, ram_din} !== e) begin
                        bad++;
                        $display("FAIL fmt_word: got %0h/%0h, want %0h/%0h", ram_addr, ram_din, e[27:16], e[15:0]);
                    end
                end
            end
            if (sd_rd || sd_wr) bad++;
            if (done) begin
                done_n++;
                done_c = c;
            end
            tick();
        end
        n_cmp++;
        if (we_n != 4 || bad != 0 || exp_fmt.size() != 0) begin
            n_bad++;
            $display("FAIL fmt_writes: got %0d writes %0d errors, want 4 0", we_n, bad);
        end
        n_cmp++;
        if (done_n != 1 || done_c != last_we + 1 || last_we != 3) begin
            n_bad++;
            $display("FAIL fmt_done: got pulses=%0d at %0d (last write %0d), want 1 at 4", done_n, done_c, last_we);
        end
        n_cmp++;
        if (dirty !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fmt_dirty: got dirty=%0b busy=%0b, want 1 0", dirty, busy);
        end
    endtask

    task automatic test_save();
        logic [31:0] l, e;
        bit t;
        int wc, b, we_sum, bad_sum;
        slot = 2'd1;
        bram_dirty = 1'b1;
        tick();
        bram_dirty = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) exp_lba.push_back(16 + i);
        save_req = 1'b1;
        tick();
        tick();
        save_req = 1'b0;
        n_cmp++;
        if ({sd_rd, sd_wr, loading, dirty} !== 4'b0100) begin
            n_bad++;
            $display("FAIL save_start: got rd/wr/loading/dirty=%b, want 0100", {sd_rd, sd_wr, loading, dirty});
        end
        we_sum = 0; bad_sum = 0;
        for (int i = 0; i < 16; i++) begin
            sd_host(1'b0, 1'b0, l, t, wc, b);
            e = exp_lba.pop_front();
            n_cmp++;
            if (t || l !== e) begin
                n_bad++;
                $display("FAIL save_lba: got %0d (timeout=%0b), want %0d", l, t, e);
            end
            we_sum += wc;
            bad_sum += b;
            if (i == 7) begin
                bram_dirty = 1'b1;
                tick();
                bram_dirty = 1'b0;
            end
        end
        n_cmp++;
        if (we_sum != 0 || bad_sum != 0) begin
            n_bad++;
            $display("FAIL save_no_we: got we=%0d anomalies=%0d, want 0 0", we_sum, bad_sum);
        end
        n_cmp++;
        if ({done, dirty, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL save_done: got done/dirty/busy=%b, want 110", {done, dirty, busy});
        end
        tick();
    endtask

    task automatic test_timeout();
        logic [31:0] l, e;
        bit t;
        int wc, b, n, dn, bad_sum;
        slot = 2'd0;
        load_req = 1'b1;
        tick();
        tick();
        load_req = 1'b0;
        n = 0; dn = 0;
        while (sd_rd && n < 200) begin
            if (done) dn++;
            n++;
            tick();
        end
        if (done) dn++;
        n_cmp++;
        if (n != 64) begin
            n_bad++;
            $display("FAIL tmo_len: got sd_rd high %0d cycles, want 64", n);
        end
        n_cmp++;
        if ({err, loading, busy} !== 3'b100 || dn != 0) begin
            n_bad++;
            $display("FAIL tmo_state: got err/loading/busy=%b done_pulses=%0d, want 100 0", {err, loading, busy}, dn);
        end
        for (int i = 0; i < 16; i++) exp_lba.push_back(i);
        save_req = 1'b1;
        tick();
        tick();
        save_req = 1'b0;
        n_cmp++;
        if (err !== 1'b0 || sd_wr !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_clear: got err=%0b wr=%0b, want 0 1", err, sd_wr);
        end
        bad_sum = 0;
        for (int i = 0; i < 16; i++) begin
            sd_host(1'b0, 1'b0, l, t, wc, b);
            e = exp_lba.pop_front();
            if (t || l !== e) bad_sum++;
            bad_sum += b + wc;
        end
        n_cmp++;
        if (bad_sum != 0 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_resave: got anomalies=%0d done=%0b, want 0 1", bad_sum, done);
        end
        tick();
    endtask

    task automatic test_both_reset();
        logic [31:0] l;
        bit t;
        int wc, b, bad_sum, act;
        slot = 2'd0;
        load_req = 1'b1;
        save_req = 1'b1;
        tick();
        tick();
        load_req = 1'b0;
        save_req = 1'b0;
        n_cmp++;
        if ({sd_rd, sd_wr, loading} !== 3'b101) begin
            n_bad++;
            $display("FAIL both_prio: got rd/wr/loading=%b, want 101", {sd_rd, sd_wr, loading});
        end
        for (int i = 0; i < 5; i++) exp_lba.push_back(i);
        bad_sum = 0;
        for (int i = 0; i < 5; i++) begin
            sd_host(1'b1, 1'b1, l, t, wc, b);
            if (t || l !== exp_lba.pop_front()) bad_sum++;
            bad_sum += b;
        end
        n_cmp++;
        if (bad_sum != 0 || sd_rd !== 1'b1 || sd_lba !== 32'd5) begin
            n_bad++;
            $display("FAIL both_sectors: got anomalies=%0d rd=%0b lba=%0d, want 0 1 5", bad_sum, sd_rd, sd_lba);
        end
        repeat (4) tick();
        sd_ack = 1'b1;
        tick();
        sd_buff_addr = 8'd3;
        sd_buff_dout = 16'hBEEF;
        sd_buff_wr = 1'b1;
        #1;
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 12'h503) begin
            n_bad++;
            $display("FAIL abort_mid: got we=%0b addr=%0h, want 1 503", ram_we, ram_addr);
        end
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({sd_lba, sd_rd, sd_wr, ram_we, ram_addr, ram_din, loading, busy, dirty, err, done} !== '0) begin
            n_bad++;
            $display("FAIL abort_reset: got lba=%0h rd=%0b wr=%0b we=%0b addr=%0h din=%0h status=%b, want all 0",
                     sd_lba, sd_rd, sd_wr, ram_we, ram_addr, ram_din, {loading, busy, dirty, err, done});
        end
        reset = 1'b0;
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        act = 0;
        repeat (6) begin
            tick();
            if (busy || sd_rd || sd_wr || done) act++;
        end
        n_cmp++;
        if (act != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: got %0d active cycles after reset, want 0", act);
        end
    endtask

    task automatic test_autosave();
        logic [31:0] l;
        bit t;
        int wc, b, c, early, bad_sum;
        slot = 2'd3;
        autosave_en = 1'b1;
        repeat (3) tick();
        for (int pass = 0; pass < 2; pass++) begin
            early = 0;
            if (pass == 1) begin
                bram_dirty = 1'b1;
                tick();
                bram_dirty = 1'b0;
                repeat (49) begin
                    tick();
                    if (sd_wr) early++;
                end
            end
            bram_dirty = 1'b1;
            tick();
            bram_dirty = 1'b0;
            c = 0;
            while (!sd_wr && c < 300) begin
                tick();
                c++;
            end
            n_cmp++;
            if (c != 102 || early != 0 || sd_lba !== 32'd48) begin
                n_bad++;
                $display("FAIL autosave_delay%0d: got %0d cycles lba=%0d early=%0d, want 102 48 0", pass, c, sd_lba, early);
            end
            for (int i = 0; i < 16; i++) exp_lba.push_back(48 + i);
            bad_sum = 0;
            for (int i = 0; i < 16; i++) begin
                sd_host(1'b0, 1'b0, l, t, wc, b);
                if (t || l !== exp_lba.pop_front()) bad_sum++;
                bad_sum += b + wc;
            end
            n_cmp++;
            if (bad_sum != 0 || done !== 1'b1 || dirty !== 1'b0) begin
                n_bad++;
                $display("FAIL autosave_xfer%0d: got anomalies=%0d done=%0b dirty=%0b, want 0 1 0", pass, bad_sum, done, dirty);
            end
            tick();
        end
        autosave_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_format();
        test_save();
        test_timeout();
        test_both_reset();
        test_autosave();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
